mips_stage_exmem_buffer: RTL and testbench
==========================================

// Module: mips_stage_exmem_buffer
// PURPOSE
//  EX->MEM pipeline boundary: registers ALU address, store data, memory control, dest reg and regwrite.
//  Feeds the memory datapath (word-addressed BAM, byte address ADDR_W+2 bits).
//  Two-entry skid buffer (main + skid) under valid/ready handshake so EX never drops work when MEM stalls.
//  Qualifies each access: misaligned / out-of-range accesses are neutralised and flagged.
// PARAMETERS
//  ADDR_L   64                   memory depth in 32-bit words (matches memory datapath ADDR_L)
//  ADDR_W   Util_Math_log2(ADDR_L)  word-address width; byte address = ADDR_W+2 bits
//  CNT_W    16                   width of saturating fault counter
// PORTS
//  ctrl          input   Data_Control_Control_T  clock + reset bundle; rising-edge clock, reset synchronous active-high
//  flush         input   1          squash both entries (branch/exception redirect)
//  in_valid      input   1          EX presents an access
//  in_ready      output  1          buffer can accept this cycle
//  in_addr       input   32         full byte address from ALU
//  in_data       input   Mips_Type_Word_T  store data
//  in_control    input   Mips_Control_Signal_Memory_Control_T  ByteEnable/ByteExtend/WriteEnable
//  in_dest       input   5          destination register
//  in_regwrite   input   1          writeback enable
//  out_valid     output  1          head entry valid to MEM
//  out_ready     input   1          MEM consumes head this cycle
//  out_addr      output  ADDR_W+2   byte address to memory datapath
//  out_data      output  Mips_Type_Word_T
//  out_control   output  Mips_Control_Signal_Memory_Control_T
//  out_dest      output  5
//  out_regwrite  output  1
//  out_fault     output  2          0 none, 1 misaligned, 2 out-of-range
//  fault_count   output  CNT_W      saturating count of faulted accepts
// BEHAVIOUR
//  Reset: main/skid valid=0, in_ready=1, all out_* data=0, out_control ByteEnable=None, WriteEnable off, fault_count=0.
//  in_ready = !skid_valid (registered state only; no comb path from out_ready). Accept = in_valid & in_ready.
//  Pop = out_valid & out_ready. Head = main register; skid holds overflow.
//  State (main_v, skid_v): EMPTY(0,0) ONE(1,0) FULL(1,1); (0,1) unreachable.
//   EMPTY: accept -> ONE.  ONE: accept&pop -> ONE (new into main); accept&!pop -> FULL (new into skid);
//   !accept&pop -> EMPTY.  FULL: pop -> ONE (skid moves to main, same edge); no accept possible.
//  Latency: accepted entry appears on out_* the cycle after accept when buffer empty or popping.
//  Ordering strictly FIFO; no entry duplicated or lost.
//  Fault qualification, computed on input, stored with entry:
//   misaligned: Half & addr[0]!=0, or Word & addr[1:0]!=0 -> fault=1 (priority over range).
//   out-of-range: in_addr[31:ADDR_W+2] != 0 -> fault=2.  ByteEnable None never faults.
//   Faulted entry: ByteEnable forced None, WriteEnable forced off, regwrite forced 0; addr/dest kept.
//  out_addr = in_addr[ADDR_W+1:0] as captured.
//  fault_count increments on each accepted faulted entry; saturates at all-ones; cleared only by reset.
//  flush: next edge main_v=skid_v=0, in_ready=1; access accepted in flush cycle discarded (still not counted);
//   pop in flush cycle is honoured by MEM, flush wins for buffer state.
//  Reset wins over flush and over any handshake in the same cycle.
// STRUCTURE
//  Package/header: fault code constants (None/Misaligned/Range), entry field widths, entry pack/unpack macros.
//  One sub-module: mips_stage_exmem_qualify (combinational fault detect + control neutralise), instantiated on input.
// TESTING
//  Reset then single Word store addr=0x10 data=0xDEADBEEF, out_ready=1 -> out_valid next cycle, out_addr=0x10, fault=0.
//  out_ready=0, push 3 entries A,B,C -> A,B accepted, in_ready=0 on C; raise out_ready -> A,B,C in order, no loss.
//  Half load addr=0x13 -> fault=1, ByteEnable None, WriteEnable off, regwrite 0, fault_count=1.
//  Word store addr=0x400 with ADDR_L=64 -> fault=2, write suppressed; addr=0x402 -> fault=1 (priority).
//  FULL state + flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, fault_count unchanged.
//  Force fault_count to all-ones via 2^CNT_W faults (CNT_W=4 build) -> holds 0xF; reset mid-FULL -> all outputs reset values.

Source files
------------

// File: rtl/mips_stage_exmem_pkg.sv
// Shared types for the EX->MEM boundary: memory control bundle, fault codes,
// buffer occupancy encodings and the stored entry layout.
package mips_stage_exmem_pkg;

  typedef logic [31:0] mips_word_t;

  typedef enum logic [1:0] {
    BE_NONE = 2'd0,
    BE_BYTE = 2'd1,
    BE_HALF = 2'd2,
    BE_WORD = 2'd3
  } byte_enable_t;

  typedef struct packed {
    byte_enable_t byte_enable;
    logic         byte_extend;
    logic         write_enable;
  } mem_control_t;

  typedef struct packed {
    logic clk;
    logic reset;
  } ctrl_t;

  localparam int DEST_W  = 5;
  localparam int FAULT_W = 2;

  localparam logic [FAULT_W-1:0] FAULT_NONE       = 2'd0;
  localparam logic [FAULT_W-1:0] FAULT_MISALIGNED = 2'd1;
  localparam logic [FAULT_W-1:0] FAULT_RANGE      = 2'd2;

  // Occupancy encodings as {main_valid, skid_valid}
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b10;
  localparam logic [1:0] ST_FULL  = 2'b11;

  // Address travels separately because its width depends on the memory depth.
  typedef struct packed {
    mips_word_t          data;
    mem_control_t        control;
    logic [DEST_W-1:0]   dest;
    logic                regwrite;
    logic [FAULT_W-1:0]  fault;
  } entry_t;

  function automatic int util_math_log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic entry_t entry_pack(input mips_word_t data,
                                        input mem_control_t control,
                                        input logic [DEST_W-1:0] dest,
                                        input logic regwrite,
                                        input logic [FAULT_W-1:0] fault);
    entry_t e;
    e.data     = data;
    e.control  = control;
    e.dest     = dest;
    e.regwrite = regwrite;
    e.fault    = fault;
    return e;
  endfunction

endpackage

// File: rtl/mips_stage_exmem_qualify.sv
// Combinational access qualification: detects misaligned / out-of-range accesses
// and neutralises the memory control and writeback of faulted accesses.
module mips_stage_exmem_qualify
  import mips_stage_exmem_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic [1:0]         addr_lo_i,
  input  logic [31:ADDR_W+2] addr_hi_i,
  input  mem_control_t       control_i,
  input  logic               regwrite_i,
  output logic [FAULT_W-1:0] fault_o,
  output mem_control_t       control_o,
  output logic               regwrite_o
);

  logic misaligned;
  logic out_of_range;

  always_comb begin
    misaligned   = 1'b0;
    out_of_range = 1'b0;
    unique case (control_i.byte_enable)
      BE_HALF: misaligned = addr_lo_i[0];
      BE_WORD: misaligned = |addr_lo_i;
      default: misaligned = 1'b0;
    endcase
    // A disabled access touches no memory, so it cannot be out of range.
    if (control_i.byte_enable != BE_NONE) out_of_range = |addr_hi_i;
  end

  always_comb begin
    fault_o    = FAULT_NONE;
    control_o  = control_i;
    regwrite_o = regwrite_i;
    if (misaligned) fault_o = FAULT_MISALIGNED;
    else if (out_of_range) fault_o = FAULT_RANGE;
    if (fault_o != FAULT_NONE) begin
      control_o.byte_enable  = BE_NONE;
      control_o.write_enable = 1'b0;
      regwrite_o             = 1'b0;
    end
  end

endmodule

// File: rtl/mips_stage_exmem_buffer.sv
// EX->MEM pipeline register built as a two-entry skid buffer; qualifies each
// access on entry and keeps a saturating count of faulted accepts.
//
// state     | meaning
// ST_EMPTY  | no entry held, out_valid low
// ST_ONE    | head in main register, skid free, in_ready high
// ST_FULL   | head in main, overflow in skid, in_ready low
module mips_stage_exmem_buffer
  import mips_stage_exmem_pkg::*;
#(
  parameter int ADDR_L = 64,
  parameter int ADDR_W = util_math_log2(ADDR_L),
  parameter int CNT_W  = 16
) (
  input  ctrl_t              ctrl_i,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [31:0]        in_addr_i,
  input  mips_word_t         in_data_i,
  input  mem_control_t       in_control_i,
  input  logic [DEST_W-1:0]  in_dest_i,
  input  logic               in_regwrite_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [ADDR_W+1:0]  out_addr_o,
  output mips_word_t         out_data_o,
  output mem_control_t       out_control_o,
  output logic [DEST_W-1:0]  out_dest_o,
  output logic               out_regwrite_o,
  output logic [FAULT_W-1:0] out_fault_o,
  output logic [CNT_W-1:0]   fault_count_o
);

  logic clk;
  logic rst;
  assign clk = ctrl_i.clk;
  assign rst = ctrl_i.reset;

  logic               main_v_q, main_v_d;
  logic               skid_v_q, skid_v_d;
  entry_t             main_e_q, main_e_d;
  entry_t             skid_e_q, skid_e_d;
  logic [ADDR_W+1:0]  main_a_q, main_a_d;
  logic [ADDR_W+1:0]  skid_a_q, skid_a_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [FAULT_W-1:0] q_fault;
  mem_control_t       q_control;
  logic               q_regwrite;
  entry_t             new_e;
  logic [ADDR_W+1:0]  new_a;
  logic               accept;
  logic               pop;

  mips_stage_exmem_qualify #(
    .ADDR_W (ADDR_W)
  ) u_qualify (
    .addr_lo_i  (in_addr_i[1:0]),
    .addr_hi_i  (in_addr_i[31:ADDR_W+2]),
    .control_i  (in_control_i),
    .regwrite_i (in_regwrite_i),
    .fault_o    (q_fault),
    .control_o  (q_control),
    .regwrite_o (q_regwrite)
  );

  // Ready depends only on registered occupancy, never on out_ready.
  assign in_ready_o = !skid_v_q;
  assign accept     = in_valid_i && in_ready_o;
  assign pop        = main_v_q && out_ready_i;

  assign new_e = entry_pack(in_data_i, q_control, in_dest_i, q_regwrite, q_fault);
  assign new_a = in_addr_i[ADDR_W+1:0];

  always_comb begin
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_e_d = main_e_q;
    skid_e_d = skid_e_q;
    main_a_d = main_a_q;
    skid_a_d = skid_a_q;
    case ({main_v_q, skid_v_q})
      ST_EMPTY: begin
        if (accept) begin
          main_v_d = 1'b1;
          main_e_d = new_e;
          main_a_d = new_a;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          main_e_d = new_e;
          main_a_d = new_a;
        end else if (accept) begin
          skid_v_d = 1'b1;
          skid_e_d = new_e;
          skid_a_d = new_a;
        end else if (pop) begin
          main_v_d = 1'b0;
        end
      end
      ST_FULL: begin
        if (pop) begin
          main_e_d = skid_e_q;
          main_a_d = skid_a_q;
          skid_v_d = 1'b0;
        end
      end
      default: begin
        main_v_d = 1'b0;
        skid_v_d = 1'b0;
      end
    endcase
    if (flush_i) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end
  end

  // A flushed accept never reaches MEM, so it is not counted either.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && !flush_i && (new_e.fault != FAULT_NONE) && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_e_q <= '0;
      skid_e_q <= '0;
      main_a_q <= '0;
      skid_a_q <= '0;
      cnt_q    <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_e_q <= main_e_d;
      skid_e_q <= skid_e_d;
      main_a_q <= main_a_d;
      skid_a_q <= skid_a_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid_o    = main_v_q;
  assign out_addr_o     = main_a_q;
  assign out_data_o     = main_e_q.data;
  assign out_control_o  = main_e_q.control;
  assign out_dest_o     = main_e_q.dest;
  assign out_regwrite_o = main_e_q.regwrite;
  assign out_fault_o    = main_e_q.fault;
  assign fault_count_o  = cnt_q;

endmodule

// File: tb/tb_mips_stage_exmem_buffer.sv
// Bench for the EX->MEM skid buffer: directed scenarios plus random traffic,
// all checked against a queue-based reference of the buffer.
module tb_mips_stage_exmem_buffer;
  import mips_stage_exmem_pkg::*;

  localparam int ADDR_L = 64;
  localparam int ADDR_W = 6;
  localparam int CNT_W  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  ctrl_t ctrl;
  assign ctrl = {clk, rst};
  always #5 clk = ~clk;

  logic               flush, in_valid, in_ready, in_regwrite;
  logic [31:0]        in_addr;
  mips_word_t         in_data;
  mem_control_t       in_control;
  logic [4:0]         in_dest;
  logic               out_valid, out_ready, out_regwrite;
  logic [ADDR_W+1:0]  out_addr;
  mips_word_t         out_data;
  mem_control_t       out_control;
  logic [4:0]         out_dest;
  logic [1:0]         out_fault;
  logic [CNT_W-1:0]   fault_count;

  mips_stage_exmem_buffer #(.ADDR_L(ADDR_L), .CNT_W(CNT_W)) dut (
    .ctrl_i(ctrl), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_addr_i(in_addr), .in_data_i(in_data), .in_control_i(in_control),
    .in_dest_i(in_dest), .in_regwrite_i(in_regwrite), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_addr_o(out_addr), .out_data_o(out_data),
    .out_control_o(out_control), .out_dest_o(out_dest), .out_regwrite_o(out_regwrite),
    .out_fault_o(out_fault), .fault_count_o(fault_count)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  ctl;
    logic [4:0]  dest;
    logic        rw;
    logic [1:0]  fault;
  } exp_t;

  exp_t q[$];
  int   model_cnt = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected entry derived from the access rules: byte memory spans 4*ADDR_L bytes.
  function automatic exp_t model_entry(input logic [31:0] a, input logic [31:0] d,
                                       input int be, input logic ext, input logic we,
                                       input logic [4:0] dest, input logic rw);
    exp_t e;
    bit mis, rng;
    mis = (be == 2 && (a % 2) != 0) || (be == 3 && (a % 4) != 0);
    rng = (be != 0) && (a >= 32'(4 * ADDR_L));
    e.addr  = 8'(a % (4 * ADDR_L));
    e.data  = d;
    e.dest  = dest;
    e.fault = mis ? 2'd1 : (rng ? 2'd2 : 2'd0);
    if (e.fault != 0) begin
      be = 0; we = 1'b0; rw = 1'b0;
    end
    e.ctl = {2'(be), ext, we};
    e.rw  = rw;
    return e;
  endfunction

  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                      input int be, input logic ext, input logic we,
                      input logic [4:0] dest, input logic rw,
                      input logic ordy, input logic fl, input logic r);
    exp_t e;
    bit   acc, pp;
    in_valid    = v;
    in_addr     = a;
    in_data     = d;
    in_control  = '{byte_enable: byte_enable_t'(be), byte_extend: ext, write_enable: we};
    in_dest     = dest;
    in_regwrite = rw;
    out_ready   = ordy;
    flush       = fl;
    rst         = r;
    @(negedge clk);
    check_eq("out_valid", 64'(out_valid), 64'(q.size() > 0));
    check_eq("in_ready", 64'(in_ready), 64'(q.size() < 2));
    check_eq("fault_count", 64'(fault_count), 64'(model_cnt));
    if (q.size() > 0) begin
      check_eq("out_addr", 64'(out_addr), 64'(q[0].addr));
      check_eq("out_data", 64'(out_data), 64'(q[0].data));
      check_eq("out_control", 64'(out_control), 64'(q[0].ctl));
      check_eq("out_dest", 64'(out_dest), 64'(q[0].dest));
      check_eq("out_regwrite", 64'(out_regwrite), 64'(q[0].rw));
      check_eq("out_fault", 64'(out_fault), 64'(q[0].fault));
    end
    acc = v && (q.size() < 2);
    pp  = ordy && (q.size() > 0);
    e   = model_entry(a, d, be, ext, we, dest, rw);
    @(posedge clk);
    if (r) begin
      q.delete();
      model_cnt = 0;
    end else begin
      if (pp) void'(q.pop_front());
      if (fl) q.delete();
      else if (acc) begin
        q.push_back(e);
        if (e.fault != 0 && model_cnt < (1 << CNT_W) - 1) model_cnt++;
      end
    end
    #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'h0, 32'h0, 0, 1'b0, 1'b0, 5'd0, 1'b0, ordy, 1'b0, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_valid"}, 64'(out_valid), 64'(0));
    check_eq({tag, "_ready"}, 64'(in_ready), 64'(1));
    check_eq({tag, "_addr"}, 64'(out_addr), 64'(0));
    check_eq({tag, "_data"}, 64'(out_data), 64'(0));
    check_eq({tag, "_ctl"}, 64'(out_control), 64'(0));
    check_eq({tag, "_dest"}, 64'(out_dest), 64'(0));
    check_eq({tag, "_rw"}, 64'(out_regwrite), 64'(0));
    check_eq({tag, "_fault"}, 64'(out_fault), 64'(0));
    check_eq({tag, "_cnt"}, 64'(fault_count), 64'(0));
  endtask

  initial begin
    step(1'b0, 32'h0, 32'h0, 0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_reset_values("rst");

    // Single word store, visible on the next cycle
    step(1'b1, 32'h10, 32'hDEADBEEF, 3, 1'b0, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("t1_valid", 64'(out_valid), 64'(1));
    check_eq("t1_addr", 64'(out_addr), 64'h10);
    check_eq("t1_data", 64'(out_data), 64'hDEADBEEF);
    check_eq("t1_fault", 64'(out_fault), 64'(0));
    idle(1'b1);
    idle(1'b1);

    // Back-pressure: A,B fill the buffer, C waits
    step(1'b1, 32'h20, 32'hA, 3, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h24, 32'hB, 3, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("t2_full_ready", 64'(in_ready), 64'(0));
    step(1'b1, 32'h28, 32'hC, 3, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h28, 32'hC, 3, 1'b0, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("t2_head_b", 64'(out_data), 64'hB);
    step(1'b1, 32'h28, 32'hC, 3, 1'b0, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("t2_head_c", 64'(out_data), 64'hC);
    idle(1'b1);
    idle(1'b1);

    // Misaligned half load
    step(1'b1, 32'h13, 32'h0, 2, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("t3_fault", 64'(out_fault), 64'(1));
    check_eq("t3_ctl", 64'(out_control), 64'(0));
    check_eq("t3_rw", 64'(out_regwrite), 64'(0));
    check_eq("t3_cnt", 64'(fault_count), 64'(1));

    // Out-of-range word store, then misaligned outranks range
    step(1'b1, 32'h400, 32'h55, 3, 1'b0, 1'b1, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("t4_fault_rng", 64'(out_fault), 64'(2));
    check_eq("t4_we", 64'(out_control.write_enable), 64'(0));
    step(1'b1, 32'h402, 32'h66, 3, 1'b0, 1'b1, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("t4_fault_mis", 64'(out_fault), 64'(1));
    check_eq("t4_cnt", 64'(fault_count), 64'(3));
    idle(1'b1);

    // Flush while FULL with a faulted access offered
    step(1'b1, 32'h30, 32'h1, 3, 1'b0, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h34, 32'h2, 3, 1'b0, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h401, 32'h3, 3, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("t5_valid", 64'(out_valid), 64'(0));
    check_eq("t5_ready", 64'(in_ready), 64'(1));
    check_eq("t5_cnt", 64'(fault_count), 64'(3));
    idle(1'b1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      int sel;
      sel = int'($urandom_range(0, 7));
      if (sel < 5) a = 32'($urandom_range(0, 255));
      else if (sel == 5) a = $urandom;
      else a = 32'($urandom_range(0, 63)) << 2;
      step(1'($urandom_range(0, 3) != 0), a, $urandom, int'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 99) == 0));
    end

    // Saturation of the fault counter
    step(1'b0, 32'h0, 32'h0, 0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 18; i++) begin
      step(1'b1, 32'h801, 32'(i), 3, 1'b0, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    check_eq("t7_sat", 64'(fault_count), 64'hF);
    idle(1'b1);
    check_eq("t7_hold", 64'(fault_count), 64'hF);

    // Reset in the middle of FULL
    step(1'b1, 32'h40, 32'h11, 3, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h44, 32'h22, 3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("t8_full", 64'(in_ready), 64'(0));
    step(1'b1, 32'h48, 32'h33, 3, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1);
    check_reset_values("t8");
    idle(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
